// File: rtl/pc_unit_pkg.sv
// Shared header for the fetch, instruction-memory and decode stages.
// Holds the icode constants, processor status encodings and default datapath width.
// No logic; also defines the PC unit's internal state type.
package pc_unit_pkg;

  localparam int DATA_WID_DEF = 32;

  // Instruction opcodes (icode field)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Processor status
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  // PC unit control state
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_unit_instr_len.sv
// Purpose: maps an icode to its instruction length in bytes.
// Latency: purely combinational. Backpressure: none.
// Ports: icode (in, 4) -> len (out, 3). Undefined icodes C-F report 1 byte.
module instr_len
  import pc_unit_pkg::*;
(
  input  logic [3:0] icode,
  output logic [2:0] len
);

  always_comb begin
    len = 3'd1;
    case (icode)
      I_HALT, I_NOP, I_RET:                len = 3'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    len = 3'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 3'd6;
      I_JXX, I_CALL:                       len = 3'd5;
      default:                             len = 3'd1;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Purpose: program counter and processor status for the fetch stage.
// Latency: PC/stat/running update 1 cycle after the edge; valP is combinational from PC.
// Backpressure: stall=1 freezes all state; HALTED and FAULT hold until rst.
// Ports: clk, rst (sync, active-high); icode, valC, valM, cnd, imem_error, stall in;
//        PC (drives imem address directly), valP, stat, running out.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                   DATA_WID = DATA_WID_DEF,
  parameter logic [DATA_WID-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          icode,
  input  logic [DATA_WID-1:0] valC,
  input  logic [DATA_WID-1:0] valM,
  input  logic                cnd,
  input  logic                imem_error,
  input  logic                stall,
  output logic [DATA_WID-1:0] PC,
  output logic [DATA_WID-1:0] valP,
  output logic [2:0]          stat,
  output logic                running
);

  logic [2:0]          len;
  logic [DATA_WID-1:0] next_pc;
  logic [DATA_WID-1:0] pc_d;
  state_t              state_q, state_d;
  stat_t               stat_q, stat_d;

  instr_len u_instr_len (
    .icode (icode),
    .len   (len)
  );

  // Fall-through address; natural wrap modulo 2^DATA_WID.
  assign valP = PC + DATA_WID'(len);

  always_comb begin
    next_pc = valP;
    case (icode)
      I_CALL:  next_pc = valC;
      I_JXX:   next_pc = cnd ? valC : valP;
      I_RET:   next_pc = valM;
      default: next_pc = valP;
    endcase
  end

  // Fault checks in priority order: address error beats illegal opcode beats halt.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    pc_d    = PC;
    if (state_q == ST_RUN && !stall) begin
      if (imem_error) begin
        state_d = ST_FAULT;
        stat_d  = STAT_ADR;
      end else if (icode > I_POPQ) begin
        state_d = ST_FAULT;
        stat_d  = STAT_INS;
      end else if (icode == I_HALT) begin
        state_d = ST_HALTED;
        stat_d  = STAT_HLT;
      end else begin
        pc_d    = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stat_q  <= STAT_AOK;
      PC      <= RESET_PC;
      running <= 1'b1;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      PC      <= pc_d;
      running <= (stat_d == STAT_AOK);
    end
  end

  assign stat = stat_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed table of cycle vectors plus a hand-written stall sequence.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic [31:0] valC, valM;
  logic        cnd, imem_error, stall;
  logic [31:0] PC, valP;
  logic [2:0]  stat;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(.DATA_WID(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .icode      (icode),
    .valC       (valC),
    .valM       (valM),
    .cnd        (cnd),
    .imem_error (imem_error),
    .stall      (stall),
    .PC         (PC),
    .valP       (valP),
    .stat       (stat),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic        stall;
    logic [3:0]  icode;
    logic [31:0] valC;
    logic [31:0] valM;
    logic        cnd;
    logic        err;
    logic        chk_valp;
    logic [31:0] exp_valp;  // before the edge
    logic [31:0] exp_pc;    // after the edge
    logic [2:0]  exp_stat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string tag, logic r, logic s, logic [3:0] ic,
                              logic [31:0] c, logic [31:0] m, logic cd, logic e,
                              logic cv, logic [31:0] vp, logic [31:0] pc, logic [2:0] st);
    vec_t v;
    v.tag = tag; v.rst = r; v.stall = s; v.icode = ic; v.valC = c; v.valM = m;
    v.cnd = cd; v.err = e; v.chk_valp = cv; v.exp_valp = vp; v.exp_pc = pc; v.exp_stat = st;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; icode = v.icode; valC = v.valC;
    valM = v.valM; cnd = v.cnd; imem_error = v.err;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; icode = 4'h1; valC = '0; valM = '0; cnd = 1'b0; imem_error = 1'b0;

    //           tag           rst stl ic     valC          valM          cnd err cv  valP          PC            stat
    vecs.push_back(mk("reset",    1, 0, 4'h1, 32'h0,        32'h0,        0, 0, 0, 32'h0,       32'h0,        3'd1));
    vecs.push_back(mk("seq_nop",  0, 0, 4'h1, 32'h0,        32'h0,        0, 0, 1, 32'h1,       32'h1,        3'd1));
    vecs.push_back(mk("seq_irm",  0, 0, 4'h3, 32'h0,        32'h0,        0, 0, 1, 32'h7,       32'h7,        3'd1));
    vecs.push_back(mk("seq_opq",  0, 0, 4'h6, 32'h0,        32'h0,        0, 0, 1, 32'h9,       32'h9,        3'd1));
    vecs.push_back(mk("to_10",    0, 0, 4'h8, 32'h10,       32'h0,        0, 0, 1, 32'hE,       32'h10,       3'd1));
    vecs.push_back(mk("jxx_nt",   0, 0, 4'h7, 32'h40,       32'h0,        0, 0, 1, 32'h15,      32'h15,       3'd1));
    vecs.push_back(mk("back_10",  0, 0, 4'h8, 32'h10,       32'h0,        0, 0, 1, 32'h1A,      32'h10,       3'd1));
    vecs.push_back(mk("jxx_tk",   0, 0, 4'h7, 32'h40,       32'h0,        1, 0, 1, 32'h15,      32'h40,       3'd1));
    vecs.push_back(mk("back_10b", 0, 0, 4'h8, 32'h10,       32'h0,        0, 0, 1, 32'h45,      32'h10,       3'd1));
    vecs.push_back(mk("call",     0, 0, 4'h8, 32'h40,       32'h0,        0, 0, 1, 32'h15,      32'h40,       3'd1));
    vecs.push_back(mk("ret",      0, 0, 4'h9, 32'h0,        32'h123,      0, 0, 1, 32'h41,      32'h123,      3'd1));
    vecs.push_back(mk("stall1",   0, 1, 4'h8, 32'h999,      32'h0,        0, 0, 1, 32'h128,     32'h123,      3'd1));
    vecs.push_back(mk("stall2",   0, 1, 4'h1, 32'h0,        32'h0,        0, 1, 1, 32'h124,     32'h123,      3'd1));
    vecs.push_back(mk("stall3",   0, 1, 4'hE, 32'h0,        32'h0,        0, 0, 1, 32'h124,     32'h123,      3'd1));
    vecs.push_back(mk("len_rr",   0, 0, 4'h2, 32'h0,        32'h0,        0, 0, 1, 32'h125,     32'h125,      3'd1));
    vecs.push_back(mk("len_push", 0, 0, 4'hA, 32'h0,        32'h0,        0, 0, 1, 32'h127,     32'h127,      3'd1));
    vecs.push_back(mk("len_pop",  0, 0, 4'hB, 32'h0,        32'h0,        0, 0, 1, 32'h129,     32'h129,      3'd1));
    vecs.push_back(mk("len_rm",   0, 0, 4'h4, 32'h0,        32'h0,        0, 0, 1, 32'h12F,     32'h12F,      3'd1));
    vecs.push_back(mk("len_mr",   0, 0, 4'h5, 32'h0,        32'h0,        0, 0, 1, 32'h135,     32'h135,      3'd1));
    vecs.push_back(mk("halt",     0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 1, 32'h136,     32'h135,      3'd2));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("halt_frz", 0, 0, 4'h1, 32'h0,      32'h0,        0, 0, 1, 32'h136,     32'h135,      3'd2));
    vecs.push_back(mk("rst_halt", 1, 0, 4'h1, 32'h0,        32'h0,        0, 0, 0, 32'h0,       32'h0,        3'd1));
    vecs.push_back(mk("to_fffe",  0, 0, 4'h9, 32'h0,        32'hFFFFFFFE, 0, 0, 1, 32'h1,       32'hFFFFFFFE, 3'd1));
    vecs.push_back(mk("wrap",     0, 0, 4'h3, 32'h0,        32'h0,        0, 0, 1, 32'h4,       32'h4,        3'd1));
    vecs.push_back(mk("adr_ins",  0, 0, 4'hE, 32'h0,        32'h0,        0, 1, 1, 32'h5,       32'h4,        3'd3));
    vecs.push_back(mk("flt_frz",  0, 0, 4'h8, 32'h80,       32'h0,        0, 0, 1, 32'h9,       32'h4,        3'd3));
    vecs.push_back(mk("rst_flt",  1, 1, 4'h8, 32'h80,       32'h0,        0, 1, 0, 32'h0,       32'h0,        3'd1));
    vecs.push_back(mk("ins",      0, 0, 4'hF, 32'h0,        32'h0,        0, 0, 1, 32'h1,       32'h0,        3'd4));
    vecs.push_back(mk("ins_frz",  0, 1, 4'h1, 32'h0,        32'h0,        0, 0, 1, 32'h1,       32'h0,        3'd4));
    vecs.push_back(mk("rst_ins",  1, 0, 4'h1, 32'h0,        32'h0,        0, 0, 0, 32'h0,       32'h0,        3'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk_valp) check({vecs[i].tag, "_valP"}, valP, vecs[i].exp_valp);
      @(posedge clk);
      #1;
      check({vecs[i].tag, "_PC"}, PC, vecs[i].exp_pc);
      check({vecs[i].tag, "_stat"}, {29'd0, stat}, {29'd0, vecs[i].exp_stat});
      check({vecs[i].tag, "_running"}, {31'd0, running}, {31'd0, (vecs[i].exp_stat == 3'd1)});
    end

    // Hand-written: long stall with varying inputs, then release into a taken branch.
    // PC is 0, stat AOK at this point.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0; stall = 1'b1; icode = 4'(k * 3 + 2); valC = 32'h55; cnd = 1'b1;
      imem_error = k[0];
      @(posedge clk);
      #1;
      check("hold_PC", PC, 32'h0);
      check("hold_stat", {29'd0, stat}, 32'd1);
    end
    @(negedge clk);
    stall = 1'b0; icode = 4'h7; valC = 32'h55; cnd = 1'b1; imem_error = 1'b0;
    @(posedge clk);
    #1;
    check("release_PC", PC, 32'h55);
    check("release_running", {31'd0, running}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter DATA_WID, default 32, giving the width of PC, valC, valM and valP.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 icode  input  4  opcode of the instruction currently fetched at PC.
REQ-007 valC  input  DATA_WID  constant field of the current instruction.
REQ-008 valM  input  DATA_WID  return address read from the stack, used for ret.
REQ-009 cnd  input  1  branch condition result for the current jXX.
REQ-010 imem_error  input  1  instruction memory address fault for the current PC.
REQ-011 stall  input  1  hold all state this cycle.
REQ-012 PC  output  DATA_WID  registered address of the instruction being fetched.
REQ-013 valP  output  DATA_WID  combinational fall-through address, PC + instruction length.
REQ-014 stat  output  3  registered processor status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-015 running  output  1  high while stat is AOK.

Function
REQ-016 Instruction length SHALL be 1 byte for icode 0, 1 and 9, and 2 bytes for icode 2, 6, A and B.
REQ-017 Instruction length SHALL be 6 bytes for icode 3, 4 and 5, and 5 bytes for icode 7 and 8.
REQ-018 valP SHALL equal PC plus the instruction length, computed modulo 2^DATA_WID.
REQ-019 For icode C–F, valP SHALL equal PC + 1, and valP is then informational only.
REQ-020 The next PC SHALL be valC for icode 8 (call), and valC for icode 7 when cnd=1.
REQ-021 The next PC SHALL be valM for icode 9 (ret), and valP in all other cases.
REQ-022 The state machine SHALL have states RUN, HALTED and FAULT, with stat distinguishing ADR from INS within FAULT.
REQ-023 In RUN with stall=0, the block SHALL evaluate conditions in priority order: imem_error, then icode > B, then icode=0.
REQ-024 If imem_error=1, the block SHALL go to FAULT with stat=ADR and hold PC.
REQ-025 Else if icode > B, the block SHALL go to FAULT with stat=INS and hold PC.
REQ-026 Else if icode=0, the block SHALL go to HALTED with stat=HLT and hold PC.
REQ-027 Otherwise the block SHALL load the next PC and keep stat=AOK.
REQ-028 When stall=1, PC and stat SHALL be unchanged, regardless of other inputs.
REQ-029 HALTED and FAULT SHALL be absorbing: PC and stat frozen until rst.
REQ-030 PC, stat and running SHALL be registered outputs with a 1-cycle update latency.
REQ-031 PC SHALL wrap modulo 2^DATA_WID with no flag and no error.

Reset
REQ-032 On rst=1 at a rising edge, the block SHALL set PC=RESET_PC, stat=AOK and state RUN.
REQ-033 Reset SHALL take priority over stall and all other inputs.
REQ-034 Reset asserted mid-operation or in HALTED/FAULT SHALL take effect at that edge.
REQ-035 Normal operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-036 The icode constants, stat encodings and DATA_WID default SHALL live in the shared header package used by the instruction memory and decode stages.
REQ-037 Length decoding SHALL be one combinational sub-module, instr_len, mapping icode to a byte count.
REQ-038 PC output SHALL drive the instruction memory PC input directly.

Verification
REQ-039 Bench SHALL cover sequential fetch: reset, then icode sequence 1,3,6 with no stall -> PC = 0, 1, 7, 9.
REQ-040 Bench SHALL cover branches at PC=0x10 with valC=0x40: icode 7 with cnd=0 -> PC=0x15; icode 7 with cnd=1 -> PC=0x40; icode 8 -> PC=0x40.
REQ-041 Bench SHALL cover ret: icode 9 with valM=0x123 -> PC=0x123, stat=1.
REQ-042 Bench SHALL cover halt and stall: stall=1 for 3 cycles -> PC constant; then icode 0 -> stat=2 and running=0, and PC stays frozen for 5 further cycles despite icode=1 inputs.
REQ-043 Bench SHALL cover faults and wrap-around.
REQ-044 Fault case: imem_error=1 together with icode=E -> stat=3 (ADR wins over INS).
REQ-045 Wrap case: PC=0xFFFFFFFE with icode 3 -> PC=0x00000004.
REQ-046 Reset from fault case: rst asserted in FAULT -> PC=0 and stat=1 on that edge.
